// File: rtl/calc2_port_responder.sv
// Responder for one calc2 request port: two-cycle command capture, add/shift
// delay pipelines with per-class latency, and an output FIFO serialising completions.
module calc2_port_responder #(
    parameter int ADD_LAT    = 1,
    parameter int SHIFT_LAT  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        fifo_ovf
);

    typedef struct packed {
        logic        v;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } entry_t;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    // state  | meaning
    // S_IDLE | waiting for a command; latches cmd/operand1/tag
    // S_OP2  | operand2 cycle; issues the request to an execute unit
    typedef enum logic {S_IDLE, S_OP2} state_t;
    state_t state_q, state_d;

    logic        latch_en, issue_en;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [1:0]  tag_q;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_cmd_in != 4'd0) state_d = S_OP2;
            S_OP2:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state_q == S_IDLE) && (req_cmd_in != 4'd0);
        issue_en = (state_q == S_OP2);
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cmd_q <= '0;
            op1_q <= '0;
            tag_q <= '0;
        end else if (latch_en) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            tag_q <= req_tag_in;
        end
    end

    // A nonzero cmd during the operand2 cycle turns the pending request into an error.
    logic [32:0] sum;
    entry_t      issue;
    logic        issue_shift;

    always_comb begin
        sum         = {1'b0, op1_q} + {1'b0, req_data_in};
        issue       = '0;
        issue_shift = 1'b0;
        if (issue_en) begin
            issue.v    = 1'b1;
            issue.tag  = tag_q;
            issue.resp = RESP_ERR;
            if (req_cmd_in == 4'd0) begin
                case (cmd_q)
                    4'd1: if (!sum[32]) begin
                        issue.resp = RESP_OK;
                        issue.data = sum[31:0];
                    end
                    4'd2: if (req_data_in <= op1_q) begin
                        issue.resp = RESP_OK;
                        issue.data = op1_q - req_data_in;
                    end
                    4'd5: begin
                        issue_shift = 1'b1;
                        issue.resp  = RESP_OK;
                        issue.data  = op1_q << req_data_in[4:0];
                    end
                    4'd6: begin
                        issue_shift = 1'b1;
                        issue.resp  = RESP_OK;
                        issue.data  = op1_q >> req_data_in[4:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    entry_t add_pipe_q [ADD_LAT];
    entry_t shf_pipe_q [SHIFT_LAT];
    entry_t add_c, shf_c;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ADD_LAT; i++)   add_pipe_q[i] <= '0;
            for (int i = 0; i < SHIFT_LAT; i++) shf_pipe_q[i] <= '0;
        end else begin
            add_pipe_q[0] <= issue_shift ? '0 : issue;
            shf_pipe_q[0] <= issue_shift ? issue : '0;
            for (int i = 1; i < ADD_LAT; i++)   add_pipe_q[i] <= add_pipe_q[i-1];
            for (int i = 1; i < SHIFT_LAT; i++) shf_pipe_q[i] <= shf_pipe_q[i-1];
        end
    end

    assign add_c = add_pipe_q[ADD_LAT-1];
    assign shf_c = shf_pipe_q[SHIFT_LAT-1];

    entry_t         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  cnt_q;
    entry_t         head_sel, w0, w1;
    logic           w0_v, w1_v, pop, drop;
    logic [1:0]     out_resp_q, out_tag_q;
    logic [31:0]    out_data_q;
    logic           ovf_q;

    // With the FIFO empty a completion bypasses straight to the output register.
    // When non-empty the head is popped this cycle, so at least one slot is free.
    always_comb begin
        head_sel = '0;
        w0       = '0;
        w1       = '0;
        w0_v     = 1'b0;
        w1_v     = 1'b0;
        drop     = 1'b0;
        pop      = (cnt_q != '0);
        if (pop) begin
            head_sel = fifo_mem[rd_q];
            w0       = shf_c.v ? shf_c : add_c;
            w0_v     = shf_c.v | add_c.v;
            if (shf_c.v && add_c.v) begin
                if (cnt_q == CW'(FIFO_DEPTH)) begin
                    drop = 1'b1;
                end else begin
                    w1   = add_c;
                    w1_v = 1'b1;
                end
            end
        end else if (shf_c.v) begin
            head_sel = shf_c;
            w0       = add_c;
            w0_v     = add_c.v;
        end else begin
            head_sel = add_c;
        end
    end

    always_ff @(posedge c_clk) begin
        if (w0_v) fifo_mem[wr_q] <= w0;
        if (w1_v) fifo_mem[wr_q + PW'(1)] <= w1;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            rd_q       <= rd_q + PW'(pop);
            wr_q       <= wr_q + PW'(w0_v) + PW'(w1_v);
            cnt_q      <= cnt_q - CW'(pop) + CW'(w0_v) + CW'(w1_v);
            ovf_q      <= ovf_q | drop;
            out_resp_q <= head_sel.v ? head_sel.resp : 2'd0;
            out_data_q <= (head_sel.v && head_sel.resp == RESP_OK) ? head_sel.data : 32'd0;
            out_tag_q  <= head_sel.v ? head_sel.tag : 2'd0;
        end
    end

    assign out_resp = out_resp_q;
    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;
    assign fifo_ovf = ovf_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: directed protocol cases plus
// randomized requests checked against a completion-time reference model.
module tb_calc2_port_responder;

    localparam int ADD_LAT    = 1;
    localparam int SHIFT_LAT  = 3;
    localparam int FIFO_DEPTH = 4;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_cmd_in = '0;
    logic [31:0] req_data_in = '0;
    logic [1:0]  req_tag_in = '0;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        fifo_ovf;

    calc2_port_responder #(
        .ADD_LAT   (ADD_LAT),
        .SHIFT_LAT (SHIFT_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .req_tag_in (req_tag_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .fifo_ovf   (fifo_ovf)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          done;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } pend_t;

    typedef struct {
        int          at;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_t;

    pend_t pending[$];
    exp_t  expq[$];
    int    last_out = 0;

    // Reference: result from plain arithmetic, completion = operand2 cycle + class latency.
    function automatic void model_issue(int t, logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                                        logic [1:0] tag, logic [3:0] cmd2);
        pend_t      p;
        logic [63:0] s;
        int          n;
        p.tag  = tag;
        p.resp = 2'd2;
        p.data = 32'd0;
        p.done = t + ADD_LAT;
        n      = int'(b % 32);
        if (cmd2 == 4'd0) begin
            case (cmd)
                4'd1: begin
                    s = 64'(a) + 64'(b);
                    if (s <= 64'h0000_0000_FFFF_FFFF) begin
                        p.resp = 2'd1;
                        p.data = s[31:0];
                    end
                end
                4'd2: if (a >= b) begin
                    p.resp = 2'd1;
                    p.data = a - b;
                end
                4'd5: begin
                    p.done = t + SHIFT_LAT;
                    p.resp = 2'd1;
                    p.data = a << n;
                end
                4'd6: begin
                    p.done = t + SHIFT_LAT;
                    p.resp = 2'd1;
                    p.data = a >> n;
                end
                default: ;
            endcase
        end
        pending.push_back(p);
    endfunction

    function automatic void model_reset();
        pending.delete();
        expq.delete();
        last_out = 0;
    endfunction

    // Scoreboard: completions of the previous cycle become scheduled outputs in
    // issue order, one per cycle; then the DUT output is compared against the schedule.
    always @(negedge c_clk) begin : scoreboard
        pend_t keep[$];
        exp_t  e;
        keep.delete();
        foreach (pending[i]) begin
            if (pending[i].done <= cyc - 1) begin
                e.at   = (pending[i].done + 1 > last_out + 1) ? pending[i].done + 1 : last_out + 1;
                e.resp = pending[i].resp;
                e.data = pending[i].data;
                e.tag  = pending[i].tag;
                last_out = e.at;
                expq.push_back(e);
            end else begin
                keep.push_back(pending[i]);
            end
        end
        pending = keep;

        checks++;
        if (expq.size() > 0 && expq[0].at == cyc) begin
            e = expq.pop_front();
            if (out_resp !== e.resp || out_data !== e.data || out_tag !== e.tag) begin
                errors++;
                $display("FAIL response cyc=%0d got resp=%0d data=%h tag=%0d want resp=%0d data=%h tag=%0d",
                         cyc, out_resp, out_data, out_tag, e.resp, e.data, e.tag);
            end
        end else if (out_resp !== 2'd0 || out_data !== 32'd0 || out_tag !== 2'd0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got resp=%0d data=%h tag=%0d want all zero",
                     cyc, out_resp, out_data, out_tag);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            tick();
            req_cmd_in  = 4'd0;
            req_data_in = $urandom;
            req_tag_in  = 2'($urandom);
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tag, input logic [3:0] cmd2);
        tick();
        req_cmd_in  = cmd;
        req_data_in = a;
        req_tag_in  = tag;
        tick();
        req_cmd_in  = cmd2;
        req_data_in = b;
        req_tag_in  = 2'($urandom);
        model_issue(cyc, cmd, a, b, tag, cmd2);
    endtask

    task automatic assert_reset(input string name);
        reset = 1'b1;
        model_reset();
        #1;
        chk({name, "_resp"}, 64'(out_resp), 64'd0);
        chk({name, "_data"}, 64'(out_data), 64'd0);
        chk({name, "_tag"},  64'(out_tag),  64'd0);
        idle_cyc(2);
        tick();
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        chk({name, "_ovf"}, 64'(fifo_ovf), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0]  c, c2;
        logic [31:0] a, b;
        int          r;

        #12;
        chk("reset_resp", 64'(out_resp), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_tag",  64'(out_tag),  64'd0);
        chk("reset_ovf",  64'(fifo_ovf), 64'd0);
        tick();
        reset = 1'b0;
        idle_cyc(2);

        send(4'd1, 32'h30, 32'h20, 2'd0, 4'd0);          idle_cyc(3);
        send(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd1, 4'd0);    idle_cyc(3);
        send(4'd2, 32'h5, 32'h6, 2'd2, 4'd0);            idle_cyc(3);
        send(4'd2, 32'h6, 32'h6, 2'd3, 4'd0);            idle_cyc(3);
        send(4'd3, 32'h1234, 32'h5678, 2'd1, 4'd0);      idle_cyc(3);
        send(4'd5, 32'h1, 32'h23, 2'd0, 4'd0);           idle_cyc(5);
        send(4'd6, 32'h8000_0000, 32'd31, 2'd3, 4'd0);   idle_cyc(5);
        // shift then add back-to-back: both complete together
        send(4'd5, 32'h1, 32'h4, 2'd3, 4'd0);
        send(4'd1, 32'h7, 32'h8, 2'd1, 4'd0);            idle_cyc(5);
        send(4'd1, 32'h10, 32'h5, 2'd2, 4'd2);           idle_cyc(4);

        send(4'd1, 32'h9, 32'h9, 2'd1, 4'd0);
        tick();
        assert_reset("reset_mid_op");
        idle_cyc(3);
        send(4'd1, 32'h1, 32'h2, 2'd0, 4'd0);            idle_cyc(3);

        send(4'd1, 32'h11, 32'h22, 2'd2, 4'd0);
        tick();
        tick();
        assert_reset("reset_on_resp");
        idle_cyc(3);

        repeat (250) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if (r < 3)      c = 4'd1;
            else if (r < 5) c = 4'd2;
            else if (r < 7) c = 4'd5;
            else if (r < 9) c = 4'd6;
            else            c = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom_range(7, 15));
            c2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            send(c, a, b, 2'($urandom), c2);
            idle_cyc($urandom_range(0, 2));
        end

        idle_cyc(12);
        chk("drain_empty", 64'(expq.size()), 64'd0);
        chk("final_ovf",   64'(fifo_ovf),    64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
